// File: rtl/mem_responder.sv
// CPU-facing memory responder: fixed-latency single-word access to a 16-bit data RAM
// and a 32-bit instruction RAM (half-word writable), with a busy/ready handshake.
module mem_responder #(
  parameter int DATA_AW  = 12,
  parameter int INSTR_AW = 12,
  parameter int LATENCY  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic        ram_read,
  input  logic        ram_write,
  input  logic        ram_instr_access,
  input  logic        ram_read_done,
  output logic [15:0] rdata,
  output logic [31:0] instr,
  output logic        mem_busy,
  output logic        mem_ready
);

  typedef enum logic [1:0] {IDLE, WAIT, RDONE, WDONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, wdata_q;
  logic        write_q, iacc_q;
  logic [15:0] rdata_q;
  logic [31:0] instr_q;
  logic        accept, do_access;
  logic        unused_addr;

  logic [15:0] dmem [2**DATA_AW];
  logic [31:0] imem [2**INSTR_AW];

  // Address bits above the RAM widths simply alias away.
  assign unused_addr = ^addr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    accept    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      IDLE: begin
        if (ram_read || ram_write) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          do_access = 1'b1;
          state_d   = write_q ? WDONE : RDONE;
        end
      end
      RDONE: begin
        if (ram_read_done) state_d = IDLE;
      end
      WDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (do_access && !write_q) begin
        if (iacc_q) instr_q <= imem[addr_q[INSTR_AW-1:0]];
        else        rdata_q <= dmem[addr_q[DATA_AW-1:0]];
      end
    end
  end

  // Request fields are captured once at acceptance; later bus changes cannot disturb the access.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      write_q <= ram_write;
      iacc_q  <= ram_instr_access;
    end
  end

  // A write landing on the same edge as reset is dropped; RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && do_access && write_q) begin
      if (iacc_q) begin
        if (addr_q[0]) imem[addr_q[INSTR_AW:1]][31:16] <= wdata_q;
        else           imem[addr_q[INSTR_AW:1]][15:0]  <= wdata_q;
      end else begin
        dmem[addr_q[DATA_AW-1:0]] <= wdata_q;
      end
    end
  end

  assign rdata     = rdata_q;
  assign instr     = instr_q;
  assign mem_busy  = (state_q == WAIT);
  assign mem_ready = (state_q == RDONE) || (state_q == WDONE);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: table of accesses with a read scoreboard, plus hand-written
// collision, in-flight request, mid-access reset and latency sweep sequences.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr, wdata;
  logic [2:0]  rd_v, wr_v;
  logic        ia, rdone;
  logic [15:0] rdata_v [3];
  logic [31:0] instr_v [3];
  logic [2:0]  busy_v, ready_v;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic        ia;
    logic [15:0] a;
    logic [15:0] wd;
    logic [15:0] er;
    logic [31:0] ei;
  } vec_t;
  vec_t vecs [13];

  always #5 clk = ~clk;

  mem_responder #(.DATA_AW(12), .INSTR_AW(12), .LATENCY(2)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .ram_read(rd_v[0]), .ram_write(wr_v[0]), .ram_instr_access(ia), .ram_read_done(rdone),
    .rdata(rdata_v[0]), .instr(instr_v[0]), .mem_busy(busy_v[0]), .mem_ready(ready_v[0]));

  mem_responder #(.DATA_AW(12), .INSTR_AW(12), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .ram_read(rd_v[1]), .ram_write(wr_v[1]), .ram_instr_access(ia), .ram_read_done(rdone),
    .rdata(rdata_v[1]), .instr(instr_v[1]), .mem_busy(busy_v[1]), .mem_ready(ready_v[1]));

  mem_responder #(.DATA_AW(12), .INSTR_AW(12), .LATENCY(15)) u_lat15 (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata),
    .ram_read(rd_v[2]), .ram_write(wr_v[2]), .ram_instr_access(ia), .ram_read_done(rdone),
    .rdata(rdata_v[2]), .instr(instr_v[2]), .mem_busy(busy_v[2]), .mem_ready(ready_v[2]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One complete access on instance sel; bus fields are scrambled right after acceptance.
  task automatic access(input int sel, input logic rd, input logic wr, input logic iacc,
                        input logic [15:0] a, input logic [15:0] wd,
                        input logic [31:0] exp, input int lat);
    int busy;
    int guard;
    logic [31:0] e;
    bit is_rd;
    is_rd = rd && !wr;
    if (is_rd) exp_q.push_back(exp);
    @(negedge clk);
    rd_v[sel] = rd; wr_v[sel] = wr; ia = iacc; addr = a; wdata = wd;
    @(negedge clk);
    rd_v = '0; wr_v = '0; addr = ~a; wdata = ~wd;
    busy = 0; guard = 0;
    while (busy_v[sel] && guard < 40) begin
      busy++; guard++;
      @(negedge clk);
    end
    check("busy_width", busy, lat);
    check("ready_on", {busy_v[sel], ready_v[sel]}, 2'b01);
    if (is_rd) begin
      e = exp_q.pop_front();
      if (iacc) check("instr_data", instr_v[sel], e);
      else      check("rdata_data", rdata_v[sel], e);
      repeat (2) @(negedge clk);
      check("ready_held", {busy_v[sel], ready_v[sel]}, 2'b01);
      rdone = 1'b1;
      @(negedge clk);
      rdone = 1'b0;
      check("ready_release", {busy_v[sel], ready_v[sel]}, 2'b00);
    end else begin
      @(negedge clk);
      check("wdone_pulse", {busy_v[sel], ready_v[sel]}, 2'b00);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    int readies;
    bit seen_busy;

    //            rd    wr    ia    addr      wdata     rdata     instr
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, 16'h0000, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 32'h00000000};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h0005, 16'h1234, 16'hBEEF, 32'h00000000};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h1234, 32'h00000000};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 16'h0008, 16'h00AA, 16'h1234, 32'h00000000};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 16'h0009, 16'h5500, 16'h1234, 32'h00000000};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 16'h1234, 32'h550000AA};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 16'h1010, 16'h0000, 16'hBEEF, 32'h550000AA};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0020, 16'h7777, 16'hBEEF, 32'h550000AA};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'hF005, 16'h4321, 16'hBEEF, 32'h550000AA};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 16'h0005, 16'h0000, 16'h4321, 32'h550000AA};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 16'h2009, 16'hAA55, 16'h4321, 32'h550000AA};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 16'h1004, 16'h0000, 16'h4321, 32'hAA5500AA};

    rst = 1'b1; rd_v = '0; wr_v = '0; ia = 1'b0; rdone = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_handshake", {busy_v[0], ready_v[0]}, 2'b00);
    check("reset_rdata", rdata_v[0], 16'h0000);
    check("reset_instr", instr_v[0], 32'h0);
    check("reset_sweep_busy", {busy_v[2], busy_v[1]}, 2'b00);

    for (int i = 0; i < 13; i++) begin
      access(0, vecs[i].rd, vecs[i].wr, vecs[i].ia, vecs[i].a, vecs[i].wd,
             vecs[i].ia ? vecs[i].ei : {16'h0, vecs[i].er}, 2);
      check("vec_rdata_hold", rdata_v[0], vecs[i].er);
      check("vec_instr_hold", instr_v[0], vecs[i].ei);
    end

    // Read and write together: only the write is served.
    access(0, 1'b1, 1'b1, 1'b0, 16'h0030, 16'hA5A5, 32'h0, 2);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0000, 32'h0000A5A5, 2);

    // A read strobe during WAIT must be dropped.
    @(negedge clk);
    rd_v[0] = 1'b1; ia = 1'b0; addr = 16'h0005;
    @(negedge clk);
    addr = 16'h0010;
    @(negedge clk);
    rd_v[0] = 1'b0;
    guard = 0;
    while (!ready_v[0] && guard < 20) begin guard++; @(negedge clk); end
    check("inflight_ready", ready_v[0], 1'b1);
    check("inflight_rdata", rdata_v[0], 16'h4321);
    rdone = 1'b1;
    @(negedge clk);
    rdone = 1'b0;
    seen_busy = 1'b0; readies = 0;
    repeat (6) begin
      seen_busy |= busy_v[0];
      readies += int'(ready_v[0]);
      @(negedge clk);
    end
    check("inflight_no_second", {31'h0, seen_busy} + readies, 0);

    // Reset in the second WAIT cycle of a write: write dropped, outputs cleared.
    @(negedge clk);
    wr_v[0] = 1'b1; ia = 1'b0; addr = 16'h0020; wdata = 16'h9999;
    @(negedge clk);
    wr_v[0] = 1'b0;
    @(negedge clk);
    check("midreset_in_wait", busy_v[0], 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midreset_handshake", {busy_v[0], ready_v[0]}, 2'b00);
    check("midreset_rdata", rdata_v[0], 16'h0000);
    check("midreset_instr", instr_v[0], 32'h0);
    access(0, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000, 32'h00007777, 2);

    // Latency extremes.
    access(1, 1'b0, 1'b1, 1'b0, 16'h0001, 16'h1111, 32'h0, 1);
    access(1, 1'b1, 1'b0, 1'b0, 16'h0001, 16'h0000, 32'h00001111, 1);
    access(2, 1'b0, 1'b1, 1'b0, 16'h0002, 16'h2222, 32'h0, 15);
    access(2, 1'b1, 1'b0, 1'b0, 16'h0002, 16'h0000, 32'h00002222, 15);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU data/instruction bus.
- Accepts single-word read and write requests from the CPU (read, write, instr-access, read-done strobes) and serves them from an internal 16-bit data RAM or a 32-bit instruction RAM.
- Each access has a fixed, parameterised wait latency.
- Drives the busy/ready handshake the CPU decoder stalls on, and returns either a 16-bit data word or a 32-bit instruction word.

Parameters:
- DATA_AW, 12: data RAM address width (2^DATA_AW x 16-bit words).
- INSTR_AW, 12: instruction RAM address width (2^INSTR_AW x 32-bit words).
- LATENCY, 2: cycles spent in WAIT per access; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  16  word address from CPU.
- wdata  in  16  write data from CPU.
- ram_read  in  1  read request.
- ram_write  in  1  write request.
- ram_instr_access  in  1  1 = access the instruction RAM, 0 = the data RAM.
- ram_read_done  in  1  CPU acknowledges read data; releases ready.
- rdata  out  16  read data (data RAM access).
- instr  out  32  instruction word (instr RAM read).
- mem_busy  out  1  high while an access is in WAIT.
- mem_ready  out  1  high while a completed access is presented.

Behaviour:
- Reset (synchronous, active-high) from any state, including mid-access:
  - state=IDLE, mem_busy=0, mem_ready=0, rdata=0, instr=0, latency counter=0.
  - A pending write is dropped.
  - RAM contents are not cleared.
- States: IDLE, WAIT, RDONE, WDONE.
- IDLE:
  - At an edge with ram_write=1 or ram_read=1, latch addr, wdata, op type and ram_instr_access; load cnt=LATENCY-1; go to WAIT.
  - ram_read and ram_write both high: write served, read ignored.
- WAIT:
  - mem_busy=1.
  - At an edge with cnt!=0: cnt decrements.
  - At an edge with cnt==0: perform the access and go to RDONE (read) or WDONE (write).
  - WAIT therefore lasts exactly LATENCY cycles.
  - For a request accepted at edge T0, mem_ready is first high in the cycle after edge T0+LATENCY.
- Read access:
  - Data RAM: rdata <= dmem[addr[DATA_AW-1:0]]; instr unchanged.
  - Instr RAM: instr <= imem[addr[INSTR_AW-1:0]]; rdata unchanged.
  - rdata and instr hold their value until the next read of the same kind or reset.
- Write access:
  - Data RAM: dmem[addr[DATA_AW-1:0]] <= wdata.
  - Instr RAM: 16-bit half-word write. addr[0]=0 writes imem[addr[INSTR_AW:1]][15:0]; addr[0]=1 writes [31:16].
- RDONE:
  - mem_ready=1, mem_busy=0.
  - Stays in RDONE until an edge with ram_read_done=1, then goes to IDLE.
  - There is no timeout.
- WDONE:
  - mem_ready=1 for exactly one cycle, then goes to IDLE unconditionally.
- Request strobes in WAIT, RDONE or WDONE are ignored, not queued.
  - The CPU must hold or re-issue a request after returning to IDLE.
  - No acceptance happens in the same cycle RDONE exits.
- ram_read_done seen in IDLE, WAIT or WDONE has no effect.
- Address wrap: bits above DATA_AW/INSTR_AW are ignored, e.g. DATA_AW=12 and addr 0x1010 aliases 0x0010.
- mem_busy and mem_ready are never high together; both are registered outputs (state decode of registered state).
- Changes to addr or wdata after acceptance have no effect on the access in flight.

Test Plan:
- Data read: preload dmem[0x010]=0xBEEF, LATENCY=2; pulse ram_read with addr=0x0010 at edge T0 → mem_busy=1 for 2 cycles; mem_ready=1 from T0+3 with rdata=0xBEEF; ready held until ram_read_done=1; IDLE one cycle after.
- Data write then read: write wdata=0x1234 to addr=0x0005 → mem_busy for LATENCY cycles, then a one-cycle mem_ready pulse; subsequent read of 0x0005 returns 0x1234.
- Instr half-writes and fetch: write 0x00AA to addr=0x0008, then 0x5500 to addr=0x0009; instr read with addr=0x0004 → instr=0x550000AA; rdata unchanged.
- Collisions: ram_read and ram_write both high in IDLE → only the write happens (read-back confirms; no RDONE entered). A new ram_read pulsed during WAIT is ignored (exactly one ready).
- Reset mid-access: assert rst during the second WAIT cycle of a write to 0x0020 (old value 0x7777) → next cycle mem_busy=0, mem_ready=0, state IDLE; dmem[0x020] still reads 0x7777.
- Latency and wrap sweep: LATENCY=1 and LATENCY=15 → busy width 1 and 15 cycles respectively; read of addr 0x1010 with DATA_AW=12 returns dmem[0x010].
